tm1638_bcd_display: RTL and testbench

- Downstream consumer of the 3-digit BCD converter output (12-bit, hundreds/tens/ones nibbles).
- Encodes each digit to 7-segment and serially drives a TM1638 display module over STB/CLK/DIO.
- Runs autonomous, periodically refreshed write frames: data command, 16-byte display RAM burst, display-control command.
- Write-only; key scanning is out of scope.

---
 rtl/tm1638_pkg.sv | 48 ++++
 rtl/seg7_encode.sv | 20 ++
 rtl/tm1638_bcd_display.sv | 207 ++++++++++++++++++++
 tb/tb_tm1638_bcd_display.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/tm1638_pkg.sv
// Shared types, command bytes and the digit-to-segment table for the TM1638 display driver.
package tm1638_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_LOAD     = 4'd1,
    ST_STB_LOW  = 4'd2,
    ST_BIT_LOW  = 4'd3,
    ST_BIT_HIGH = 4'd4,
    ST_STB_HIGH = 4'd5,
    ST_GAP      = 4'd6,
    ST_DONE     = 4'd7,
    ST_WAIT     = 4'd8
  } state_t;

  localparam logic [7:0] CMD_DATA_WR = 8'h40;
  localparam logic [7:0] CMD_ADDR0   = 8'hC0;
  localparam logic [7:0] CMD_DISP_ON = 8'h88;
  localparam logic [7:0] SEG_BLANK   = 8'h00;
  localparam logic [7:0] SEG_DASH    = 8'h40;
  localparam logic [4:0] FRAME_BYTES = 5'd19;

  // Segment pattern in gfedcba order; anything that is not a decimal digit shows a dash.
  function automatic logic [7:0] digit_to_seg(input logic [3:0] digit);
    logic [7:0] seg;
    case (digit)
      4'd0:    seg = 8'h3F;
      4'd1:    seg = 8'h06;
      4'd2:    seg = 8'h5B;
      4'd3:    seg = 8'h4F;
      4'd4:    seg = 8'h66;
      4'd5:    seg = 8'h6D;
      4'd6:    seg = 8'h7D;
      4'd7:    seg = 8'h07;
      4'd8:    seg = 8'h7F;
      4'd9:    seg = 8'h6F;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// One digit of 7-segment encoding; the blank flag only suppresses a real zero digit.
module seg7_encode
  import tm1638_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [7:0] code
);

  // Blanking never hides an out-of-range nibble, which must still show its dash.
  always_comb begin
    code = SEG_BLANK;
    if (blank && (nibble <= 4'd9)) begin
      code = SEG_BLANK;
    end else begin
      code = digit_to_seg(nibble);
    end
  end

endmodule

// File: rtl/tm1638_bcd_display.sv
// Periodically writes a 3-digit BCD value to a TM1638 module: data command, 16-byte RAM burst,
// display-control command, each in its own strobe group, bit-banged LSB first.
module tm1638_bcd_display
  import tm1638_pkg::*;
#(
  parameter int         CLK_DIV        = 4,
  parameter int         GAP_CYCLES     = 8,
  parameter int         REFRESH_CYCLES = 100000,
  parameter logic [2:0] BRIGHTNESS     = 3'd7,
  parameter bit         BLANK_LZ       = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] bcd_in,
  output logic        tm_stb,
  output logic        tm_clk,
  output logic        tm_dio,
  output logic        busy,
  output logic        frame_done
);

  localparam int DIV_MAX = max3(CLK_DIV, GAP_CYCLES, REFRESH_CYCLES);
  localparam int DIV_W   = $clog2(DIV_MAX + 1);
  localparam logic [DIV_W-1:0] CLK_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'(GAP_CYCLES - 1);
  localparam logic [DIV_W-1:0] REF_LAST = DIV_W'(REFRESH_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);

  state_t           state_r;
  logic [DIV_W-1:0] div_r;
  logic [2:0]       bit_cnt_r;
  logic [4:0]       byte_idx_r;
  logic [11:0]      bcd_r;

  logic       hund_blank_s, tens_blank_s;
  logic [7:0] hund_seg_s, tens_seg_s, ones_seg_s;
  logic [4:0] sel_idx_s;
  logic [2:0] sel_bit_s;
  logic [7:0] tx_byte_s;
  logic       group_last_s;

  assign hund_blank_s = BLANK_LZ && (bcd_r[11:8] == 4'd0);
  assign tens_blank_s = BLANK_LZ && (bcd_r[11:4] == 8'd0);

  seg7_encode u_hund (.nibble(bcd_r[11:8]), .blank(hund_blank_s), .code(hund_seg_s));
  seg7_encode u_tens (.nibble(bcd_r[7:4]),  .blank(tens_blank_s), .code(tens_seg_s));
  seg7_encode u_ones (.nibble(bcd_r[3:0]),  .blank(1'b0),         .code(ones_seg_s));

  // Point at the bit that goes on DIO at the next falling serial-clock edge.
  always_comb begin
    sel_idx_s = byte_idx_r;
    sel_bit_s = bit_cnt_r;
    if (state_r == ST_BIT_HIGH) begin
      sel_bit_s = bit_cnt_r + 3'd1;
      if (bit_cnt_r == 3'd7) begin
        sel_idx_s = byte_idx_r + 5'd1;
      end else begin
        sel_idx_s = byte_idx_r;
      end
    end else begin
      sel_bit_s = bit_cnt_r;
    end
  end

  // Frame byte mux: index 0 = G1, 1..17 = G2 (address cmd + RAM 0..15), 18 = G3.
  always_comb begin
    case (sel_idx_s)
      5'd0:    tx_byte_s = CMD_DATA_WR;
      5'd1:    tx_byte_s = CMD_ADDR0;
      5'd12:   tx_byte_s = hund_seg_s;
      5'd14:   tx_byte_s = tens_seg_s;
      5'd16:   tx_byte_s = ones_seg_s;
      5'd18:   tx_byte_s = CMD_DISP_ON | {5'd0, BRIGHTNESS};
      default: tx_byte_s = SEG_BLANK;
    endcase
  end

  assign group_last_s = (byte_idx_r == 5'd0) || (byte_idx_r == 5'd17) || (byte_idx_r == 5'd18);

  // Frame sequencer; every bus pin and status flag is a register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      div_r      <= DIV_ZERO;
      bit_cnt_r  <= 3'd0;
      byte_idx_r <= 5'd0;
      bcd_r      <= 12'd0;
      tm_stb     <= 1'b1;
      tm_clk     <= 1'b1;
      tm_dio     <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_r <= ST_LOAD;
          busy    <= 1'b1;
        end
        ST_LOAD: begin
          bcd_r      <= bcd_in;
          byte_idx_r <= 5'd0;
          bit_cnt_r  <= 3'd0;
          div_r      <= DIV_ZERO;
          tm_stb     <= 1'b0;
          state_r    <= ST_STB_LOW;
        end
        ST_STB_LOW: begin
          if (div_r == CLK_LAST) begin
            div_r   <= DIV_ZERO;
            tm_clk  <= 1'b0;
            tm_dio  <= tx_byte_s[sel_bit_s];
            state_r <= ST_BIT_LOW;
          end else begin
            div_r <= div_r + DIV_ONE;
          end
        end
        ST_BIT_LOW: begin
          if (div_r == CLK_LAST) begin
            div_r   <= DIV_ZERO;
            tm_clk  <= 1'b1;
            state_r <= ST_BIT_HIGH;
          end else begin
            div_r <= div_r + DIV_ONE;
          end
        end
        ST_BIT_HIGH: begin
          if (div_r == CLK_LAST) begin
            div_r     <= DIV_ZERO;
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if ((bit_cnt_r == 3'd7) && group_last_s) begin
              byte_idx_r <= byte_idx_r + 5'd1;
              state_r    <= ST_STB_HIGH;
            end else begin
              if (bit_cnt_r == 3'd7) begin
                byte_idx_r <= byte_idx_r + 5'd1;
              end else begin
                byte_idx_r <= byte_idx_r;
              end
              tm_clk  <= 1'b0;
              tm_dio  <= tx_byte_s[sel_bit_s];
              state_r <= ST_BIT_LOW;
            end
          end else begin
            div_r <= div_r + DIV_ONE;
          end
        end
        ST_STB_HIGH: begin
          if (div_r == CLK_LAST) begin
            div_r   <= DIV_ZERO;
            tm_stb  <= 1'b1;
            tm_dio  <= 1'b1;
            state_r <= ST_GAP;
          end else begin
            div_r <= div_r + DIV_ONE;
          end
        end
        ST_GAP: begin
          if (div_r == GAP_LAST) begin
            div_r <= DIV_ZERO;
            if (byte_idx_r == FRAME_BYTES) begin
              busy       <= 1'b0;
              frame_done <= 1'b1;
              state_r    <= ST_DONE;
            end else begin
              tm_stb  <= 1'b0;
              state_r <= ST_STB_LOW;
            end
          end else begin
            div_r <= div_r + DIV_ONE;
          end
        end
        ST_DONE: begin
          // The DONE cycle is the first idle cycle, so WAIT starts counting from one.
          frame_done <= 1'b0;
          if (REF_LAST == DIV_ZERO) begin
            div_r   <= DIV_ZERO;
            busy    <= 1'b1;
            state_r <= ST_LOAD;
          end else begin
            div_r   <= DIV_ONE;
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (div_r == REF_LAST) begin
            div_r   <= DIV_ZERO;
            busy    <= 1'b1;
            state_r <= ST_LOAD;
          end else begin
            div_r <= div_r + DIV_ONE;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          div_r      <= DIV_ZERO;
          tm_stb     <= 1'b1;
          tm_clk     <= 1'b1;
          tm_dio     <= 1'b1;
          busy       <= 1'b0;
          frame_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tm1638_bcd_display.sv
// Scoreboard bench: expected frames are queued when bcd_in is set; a bus monitor decodes
// the TM1638 serial stream and checks each completed frame and the bus timing.
module tb_tm1638_bcd_display;

  localparam int CLK_DIV = 2;
  localparam int GAP     = 3;
  localparam int REFRESH = 20;
  localparam int BUDGET  = 3000;

  logic        clk = 1'b0;
  logic        rst_a, rst_b, sel;
  logic [11:0] bcd;
  logic        stb_a, clk_a, dio_a, busy_a, fd_a;
  logic        stb_b, clk_b, dio_b, busy_b, fd_b;
  logic        stb_m, clk_m, dio_m, busy_m, fd_m, rst_m;

  int n_checks = 0;
  int n_fail   = 0;
  logic [151:0] exp_q[$];

  always #5 clk = ~clk;

  tm1638_bcd_display #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP), .REFRESH_CYCLES(REFRESH),
                       .BRIGHTNESS(3'd7), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst_a), .bcd_in(bcd), .tm_stb(stb_a), .tm_clk(clk_a), .tm_dio(dio_a),
    .busy(busy_a), .frame_done(fd_a));

  tm1638_bcd_display #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP), .REFRESH_CYCLES(REFRESH),
                       .BRIGHTNESS(3'd7), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst(rst_b), .bcd_in(bcd), .tm_stb(stb_b), .tm_clk(clk_b), .tm_dio(dio_b),
    .busy(busy_b), .frame_done(fd_b));

  assign stb_m  = sel ? stb_b  : stb_a;
  assign clk_m  = sel ? clk_b  : clk_a;
  assign dio_m  = sel ? dio_b  : dio_a;
  assign busy_m = sel ? busy_b : busy_a;
  assign fd_m   = sel ? fd_b   : fd_a;
  assign rst_m  = sel ? rst_b  : rst_a;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] seg_of(input logic [3:0] n);
    logic [7:0] tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    if (n > 4'd9) return 8'h40;
    return tab[int'(n)];
  endfunction

  // Whole frame as 19 bytes in transmission order, byte i at bits [8i +: 8].
  function automatic logic [151:0] model(input logic [11:0] v, input bit lz);
    logic [151:0] f;
    logic [3:0] h, t, o;
    h = v[11:8]; t = v[7:4]; o = v[3:0];
    f = '0;
    f[0*8 +: 8]  = 8'h40;
    f[1*8 +: 8]  = 8'hC0;
    f[12*8 +: 8] = (lz && h == 4'd0) ? 8'h00 : seg_of(h);
    f[14*8 +: 8] = (lz && h == 4'd0 && t == 4'd0) ? 8'h00 : seg_of(t);
    f[16*8 +: 8] = seg_of(o);
    f[18*8 +: 8] = 8'h8F;
    return f;
  endfunction

  task automatic drive(input logic [11:0] v);
    bcd = v;
    exp_q.push_back(model(v, !sel));
  endtask

  task automatic wait_done(input string what);
    int k;
    for (k = 0; k < BUDGET; k++) begin
      @(negedge clk);
      if (fd_m) break;
    end
    chk({"frame_done_within_budget ", what}, 32'(k < BUDGET), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_busy();
    int k;
    for (k = 0; k < BUDGET; k++) begin
      @(negedge clk);
      if (busy_m) break;
    end
    chk("busy_within_budget", 32'(k < BUDGET), 32'd1);
  endtask

  // Monitor state
  logic         m_pclk, m_pstb, m_pdio, m_pbusy, m_prst;
  int           m_clk_run, m_dio_run, m_stb_run;
  int           m_nbits, m_nbytes, m_gbytes, m_ngroups, m_rf_cnt;
  int           m_gsz [3];
  bit           m_seen_rise, m_rf_armed;
  logic [7:0]   m_sh;
  logic [151:0] m_got, m_exp;

  initial begin
    m_pclk = 1'b1; m_pstb = 1'b1; m_pdio = 1'b1; m_pbusy = 1'b0; m_prst = 1'b0;
    m_clk_run = 0; m_dio_run = 0; m_stb_run = 0; m_rf_cnt = 0; m_rf_armed = 1'b0;
    m_nbits = 0; m_nbytes = 0; m_gbytes = 0; m_ngroups = 0; m_seen_rise = 1'b0;
    m_sh = 8'h00; m_got = '0;
    forever begin
      @(negedge clk);
      if (!rst_m) begin
        if (!m_prst) chk("reset_outputs", {stb_m, clk_m, dio_m, busy_m, fd_m}, 5'b11100);
        m_nbits = 0; m_nbytes = 0; m_gbytes = 0; m_ngroups = 0; m_seen_rise = 1'b0;
        m_rf_armed = 1'b0; m_got = '0;
      end else begin
        if (m_rf_armed) m_rf_cnt++;
        if (busy_m && !m_pbusy && m_rf_armed) begin
          chk("refresh_gap", m_rf_cnt, REFRESH);
          m_rf_armed = 1'b0;
        end
        if (!stb_m && m_pstb) begin
          if (m_ngroups > 0) chk("stb_gap_min", 32'(m_stb_run >= GAP), 32'd1);
          chk("busy_at_group_start", busy_m, 1'b1);
          m_gbytes = 0; m_nbits = 0; m_seen_rise = 1'b0;
        end
        if (!stb_m && clk_m && !m_pclk) begin
          chk("clk_low_len", m_clk_run, CLK_DIV);
          chk("dio_setup", 32'((dio_m == m_pdio) && (m_dio_run >= CLK_DIV)), 32'd1);
          m_sh = {dio_m, m_sh[7:1]};
          m_nbits++;
          m_seen_rise = 1'b1;
          if (m_nbits == 8) begin
            if (m_nbytes < 19) m_got[m_nbytes*8 +: 8] = m_sh;
            m_nbytes++; m_gbytes++; m_nbits = 0;
          end
        end
        if (!stb_m && !clk_m && m_pclk && m_seen_rise) chk("clk_high_len", m_clk_run, CLK_DIV);
        if (stb_m && !m_pstb) begin
          if (m_ngroups < 3) m_gsz[m_ngroups] = (m_nbits == 0) ? m_gbytes : 255;
          m_ngroups++;
        end
        if (fd_m) begin
          chk("busy_low_at_done", busy_m, 1'b0);
          chk("frame_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            m_exp = exp_q.pop_front();
            chk("group_sizes", {8'(m_ngroups), 8'(m_gsz[0]), 8'(m_gsz[1]), 8'(m_gsz[2])},
                {8'd3, 8'd1, 8'd17, 8'd1});
            chk("byte_count", m_nbytes, 19);
            for (int i = 0; i < 19; i++)
              chk($sformatf("frame_byte_%0d", i), m_got[i*8 +: 8], m_exp[i*8 +: 8]);
          end
          m_nbits = 0; m_nbytes = 0; m_gbytes = 0; m_ngroups = 0; m_got = '0;
          m_rf_armed = 1'b1; m_rf_cnt = 0;
        end
      end
      m_clk_run = (clk_m == m_pclk) ? m_clk_run + 1 : 1;
      m_dio_run = (dio_m == m_pdio) ? m_dio_run + 1 : 1;
      m_stb_run = (stb_m == m_pstb) ? m_stb_run + 1 : 1;
      m_pclk = clk_m; m_pdio = dio_m; m_pstb = stb_m; m_pbusy = busy_m; m_prst = rst_m;
    end
  end

  initial begin
    logic [11:0] vals [4] = '{12'h005, 12'h076, 12'h000, 12'h2A3};
    sel = 1'b0; rst_a = 1'b0; rst_b = 1'b0; bcd = 12'h243;
    repeat (3) @(posedge clk); #1;
    drive(12'h243);
    rst_a = 1'b1;

    // bcd_in changes mid-G2: current frame keeps 243, the next one shows 198
    wait_busy();
    repeat (200) @(posedge clk); #1;
    drive(12'h198);
    wait_done("f243");
    wait_done("f198");

    for (int i = 0; i < 4; i++) begin
      drive(vals[i]);
      wait_done("directed");
    end
    for (int i = 0; i < 3; i++) begin
      drive(12'($urandom_range(0, 4095)));
      wait_done("random");
    end

    // Reset in the middle of a byte, then a fresh frame
    wait_busy();
    repeat (150) @(posedge clk); #1;
    rst_a = 1'b0;
    repeat (3) @(posedge clk); #1;
    exp_q.delete();
    drive(12'h198);
    rst_a = 1'b1;
    wait_done("after_reset");
    rst_a = 1'b0;

    // Instance without leading-zero blanking
    repeat (2) @(posedge clk); #1;
    sel = 1'b1;
    drive(12'h000);
    rst_b = 1'b1;
    wait_done("nb_000");
    drive(12'h2A3);
    wait_done("nb_2A3");
    drive(12'($urandom_range(0, 4095)));
    wait_done("nb_random");
    rst_b = 1'b0;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
